// File: rtl/alu_pkg.sv
// Shared types for the 65C02 execute stage: op codes, flag masks, FSM states
// and the flag bundle carried between the datapath and the output registers.
package alu_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned MASK_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ORA = 4'd0,
        OP_AND = 4'd1,
        OP_EOR = 4'd2,
        OP_ADC = 4'd3,
        OP_SBC = 4'd4,
        OP_CMP = 4'd5,
        OP_ASL = 4'd6,
        OP_LSR = 4'd7,
        OP_ROL = 4'd8,
        OP_ROR = 4'd9,
        OP_INC = 4'd10,
        OP_DEC = 4'd11,
        OP_BIT = 4'd12
    } alu_op_t;

    // Flag-mask bit order is {N,V,Z,C}
    localparam logic [MASK_W-1:0] MASK_NONE = 4'b0000;
    localparam logic [MASK_W-1:0] MASK_NZ   = 4'b1010;
    localparam logic [MASK_W-1:0] MASK_NZC  = 4'b1011;
    localparam logic [MASK_W-1:0] MASK_NVZC = 4'b1111;
    localparam logic [MASK_W-1:0] MASK_NVZ  = 4'b1110;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXEC    = 2'd1,
        ST_DEC_ADJ = 2'd2
    } alu_state_t;

    typedef struct packed {
        logic n;
        logic v;
        logic z;
        logic c;
    } alu_flags_t;

    // Flags outside the op's mask keep their previous value
    function automatic alu_flags_t merge_flags(input alu_flags_t old_f,
                                               input alu_flags_t new_f,
                                               input logic [MASK_W-1:0] mask);
        alu_flags_t f;
        f.n = mask[3] ? new_f.n : old_f.n;
        f.v = mask[2] ? new_f.v : old_f.v;
        f.z = mask[1] ? new_f.z : old_f.z;
        f.c = mask[0] ? new_f.c : old_f.c;
        return f;
    endfunction

endpackage

// File: rtl/alu_execute_bcd_adjust.sv
// bcd_adjust: combinational 65C02 decimal correction of a binary ADC/SBC result.
// Only instantiated when ALU_DECIMAL_EN is defined.
module bcd_adjust
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] bin_sum_i,
    input  logic              nibble_carry_i,
    input  logic              carry_i,
    input  alu_op_t           op_i,
    output logic [DATA_W-1:0] adj_o,
    output logic              carry_o
);

    logic [5:0] lo_raw;
    logic [5:0] lo_adj;
    logic [5:0] hi_raw;
    logic [5:0] hi_adj;

    always_comb begin
        lo_raw  = '0;
        lo_adj  = '0;
        hi_raw  = '0;
        hi_adj  = '0;
        adj_o   = bin_sum_i;
        carry_o = carry_i;
        if (op_i == OP_ADC) begin
            // Rebuild the raw nibble sums, then carry the corrected low digit upward
            lo_raw  = {1'b0, nibble_carry_i, bin_sum_i[3:0]};
            lo_adj  = (lo_raw > 6'd9) ? lo_raw + 6'd6 : lo_raw;
            hi_raw  = {1'b0, carry_i, bin_sum_i[7:4]} - 6'(nibble_carry_i)
                      + 6'(lo_adj > 6'd15);
            hi_adj  = (hi_raw > 6'd9) ? hi_raw + 6'd6 : hi_raw;
            adj_o   = {hi_adj[3:0], lo_adj[3:0]};
            carry_o = (hi_adj > 6'd15);
        end else begin
            adj_o = bin_sum_i - (nibble_carry_i ? 8'h00 : 8'h06)
                              - (carry_i ? 8'h00 : 8'h60);
        end
    end

endmodule

// File: rtl/alu_execute.sv
// 65C02 execute stage: latched operands, registered result/flags/mask.
// Decimal ADC/SBC (extra DEC_ADJ cycle) is built only when ALU_DECIMAL_EN is defined.
module alu_execute
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              compute_step,
    input  logic [OP_W-1:0]   alu_op,
    input  logic [WIDTH-1:0]  a_in,
    input  logic [WIDTH-1:0]  b_in,
    input  logic              c_carry,
    input  logic              d_decimal,
    output logic              busy,
    output logic              result_valid,
    output logic [WIDTH-1:0]  result,
    output logic              flag_n,
    output logic              flag_v,
    output logic              flag_z,
    output logic              flag_c,
    output logic [MASK_W-1:0] flag_mask
);

    localparam int unsigned SUM_W = WIDTH + 1;

    alu_state_t        state_q, state_d;
    alu_op_t           op_q;
    logic [WIDTH-1:0]  a_q, b_q;
    logic              cin_q;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic [WIDTH-1:0]  result_q, result_d;
    alu_flags_t        flags_q, flags_d;
    logic [MASK_W-1:0] mask_q, mask_d;
    logic              accept;

    logic [WIDTH-1:0]  b_eff;
    logic              cin_eff;
    logic [SUM_W-1:0]  sum;
    logic              v_bin;
    logic [WIDTH-1:0]  ex_res;
    logic              ex_c;
    logic [MASK_W-1:0] ex_mask;
    alu_flags_t        ex_flags;
    logic              dec_path;

    assign accept = (state_q == ST_IDLE) && compute_step;

    // Single-cycle datapath on the latched operands
    always_comb begin
        b_eff   = (op_q == OP_SBC || op_q == OP_CMP) ? ~b_q : b_q;
        cin_eff = (op_q == OP_CMP) ? 1'b1 : cin_q;
        sum     = {1'b0, a_q} + {1'b0, b_eff} + SUM_W'(cin_eff);
        v_bin   = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
        ex_res  = a_q;
        ex_c    = sum[WIDTH];
        ex_mask = MASK_NONE;
        case (op_q)
            OP_ORA: begin ex_res = a_q | b_q; ex_mask = MASK_NZ; end
            OP_AND: begin ex_res = a_q & b_q; ex_mask = MASK_NZ; end
            OP_EOR: begin ex_res = a_q ^ b_q; ex_mask = MASK_NZ; end
            OP_ADC: begin ex_res = sum[WIDTH-1:0]; ex_mask = MASK_NVZC; end
            OP_SBC: begin ex_res = sum[WIDTH-1:0]; ex_mask = MASK_NVZC; end
            OP_CMP: begin ex_res = sum[WIDTH-1:0]; ex_mask = MASK_NZC; end
            OP_ASL: begin ex_res = {a_q[WIDTH-2:0], 1'b0};  ex_c = a_q[WIDTH-1]; ex_mask = MASK_NZC; end
            OP_LSR: begin ex_res = {1'b0, a_q[WIDTH-1:1]};  ex_c = a_q[0];       ex_mask = MASK_NZC; end
            OP_ROL: begin ex_res = {a_q[WIDTH-2:0], cin_q}; ex_c = a_q[WIDTH-1]; ex_mask = MASK_NZC; end
            OP_ROR: begin ex_res = {cin_q, a_q[WIDTH-1:1]}; ex_c = a_q[0];       ex_mask = MASK_NZC; end
            OP_INC: begin ex_res = a_q + WIDTH'(1); ex_mask = MASK_NZ; end
            OP_DEC: begin ex_res = a_q - WIDTH'(1); ex_mask = MASK_NZ; end
            OP_BIT: begin ex_res = a_q; ex_mask = MASK_NVZ; end
            default: begin ex_res = a_q; ex_mask = MASK_NONE; end
        endcase
        ex_flags = '{n: ex_res[WIDTH-1], v: v_bin, z: (ex_res == '0), c: ex_c};
        if (op_q == OP_BIT) begin
            ex_flags = '{n: b_q[WIDTH-1], v: b_q[WIDTH-2], z: ((a_q & b_q) == '0), c: ex_c};
        end
    end

`ifdef ALU_DECIMAL_EN
    logic              d_q;
    logic [SUM_W-1:0]  dsum_q;
    logic              dhc_q;
    logic              dv_q;
    logic [4:0]        lo_sum;
    logic [WIDTH-1:0]  adj;
    logic              adj_c;

    assign lo_sum   = {1'b0, a_q[3:0]} + {1'b0, b_eff[3:0]} + 5'(cin_eff);
    assign dec_path = d_q && (op_q == OP_ADC || op_q == OP_SBC);

    // Binary intermediate held across the adjust cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            d_q    <= 1'b0;
            dsum_q <= '0;
            dhc_q  <= 1'b0;
            dv_q   <= 1'b0;
        end else begin
            if (accept) begin
                d_q <= d_decimal;
            end
            if (state_q == ST_EXEC && dec_path) begin
                dsum_q <= sum;
                dhc_q  <= lo_sum[4];
                dv_q   <= v_bin;
            end
        end
    end

    bcd_adjust u_bcd_adjust (
        .bin_sum_i      (dsum_q[WIDTH-1:0]),
        .nibble_carry_i (dhc_q),
        .carry_i        (dsum_q[WIDTH]),
        .op_i           (op_q),
        .adj_o          (adj),
        .carry_o        (adj_c)
    );
`else
    logic unused_decimal;
    assign unused_decimal = d_decimal;
    assign dec_path       = 1'b0;
`endif

    // Next-state and output-register update
    always_comb begin
        state_d  = state_q;
        valid_d  = 1'b0;
        result_d = result_q;
        flags_d  = flags_q;
        mask_d   = mask_q;
        case (state_q)
            ST_IDLE: begin
                if (compute_step) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (dec_path) begin
                    state_d = ST_DEC_ADJ;
                end else begin
                    result_d = ex_res;
                    flags_d  = merge_flags(flags_q, ex_flags, ex_mask);
                    mask_d   = ex_mask;
                    valid_d  = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
`ifdef ALU_DECIMAL_EN
            ST_DEC_ADJ: begin
                result_d = adj;
                flags_d  = '{n: adj[WIDTH-1], v: dv_q, z: (adj == '0), c: adj_c};
                mask_d   = MASK_NVZC;
                valid_d  = 1'b1;
                state_d  = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_ORA;
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
            mask_q   <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            mask_q   <= mask_d;
            if (accept) begin
                op_q  <= alu_op_t'(alu_op);
                a_q   <= a_in;
                b_q   <= b_in;
                cin_q <= c_carry;
            end
        end
    end

    assign busy         = busy_q;
    assign result_valid = valid_q;
    assign result       = result_q;
    assign flag_n       = flags_q.n;
    assign flag_v       = flags_q.v;
    assign flag_z       = flags_q.z;
    assign flag_c       = flags_q.c;
    assign flag_mask    = mask_q;

endmodule

// File: tb/tb_alu_execute.sv
// Self-checking bench for alu_execute against an arithmetic reference model;
// expectations follow ALU_DECIMAL_EN the same way the design does.
module tb_alu_execute;

    typedef struct packed {
        logic [7:0] res;
        logic       n;
        logic       v;
        logic       z;
        logic       c;
        logic [3:0] mask;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic       compute_step;
    logic [3:0] alu_op;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       c_carry;
    logic       d_decimal;
    logic       busy;
    logic       result_valid;
    logic [7:0] result;
    logic       flag_n, flag_v, flag_z, flag_c;
    logic [3:0] flag_mask;

    int   n_checks;
    int   n_fail;
    exp_t model_q;

    alu_execute dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .compute_step (compute_step),
        .alu_op       (alu_op),
        .a_in         (a_in),
        .b_in         (b_in),
        .c_carry      (c_carry),
        .d_decimal    (d_decimal),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result),
        .flag_n       (flag_n),
        .flag_v       (flag_v),
        .flag_z       (flag_z),
        .flag_c       (flag_c),
        .flag_mask    (flag_mask)
    );

    always #5 clk = ~clk;

    // Reference: 65C02 semantics in plain integer arithmetic
    function automatic exp_t model(input int op, input int a, input int b, input int c,
                                   input int d, input exp_t prev, output int lat);
        exp_t e;
        int r, s, sa, sb, lo, hi;
        bit nn, vv, zz, cc, dec;
        logic [3:0] m;
        e = prev; lat = 1; r = a; cc = 1'b0; vv = 1'b0; m = 4'b0000;
`ifdef ALU_DECIMAL_EN
        dec = (d != 0);
`else
        dec = 1'b0;
`endif
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        case (op)
            0: begin r = a | b; m = 4'b1010; end
            1: begin r = a & b; m = 4'b1010; end
            2: begin r = a ^ b; m = 4'b1010; end
            3: begin
                s = a + b + c; r = s % 256; cc = (s > 255); m = 4'b1111;
                vv = (sa + sb + c > 127) || (sa + sb + c < -128);
                if (dec) begin
                    lo = a % 16 + b % 16 + c;
                    if (lo > 9) lo = lo + 6;
                    hi = a / 16 + b / 16 + ((lo > 15) ? 1 : 0);
                    if (hi > 9) hi = hi + 6;
                    r = (hi % 16) * 16 + lo % 16; cc = (hi > 15); lat = 2;
                end
            end
            4: begin
                s = a + (255 - b) + c; r = s % 256; cc = (s > 255); m = 4'b1111;
                vv = (sa - sb - (1 - c) > 127) || (sa - sb - (1 - c) < -128);
                if (dec) begin
                    if (a % 16 + (15 - b % 16) + c < 16) r = r - 6;
                    if (!cc) r = r - 96;
                    r = (r + 256) % 256; lat = 2;
                end
            end
            5:  begin r = (a - b + 256) % 256; cc = (a >= b); m = 4'b1011; end
            6:  begin r = (a * 2) % 256;     cc = (a > 127); m = 4'b1011; end
            7:  begin r = a / 2;             cc = (a % 2 != 0); m = 4'b1011; end
            8:  begin r = (a * 2 + c) % 256; cc = (a > 127); m = 4'b1011; end
            9:  begin r = a / 2 + c * 128;   cc = (a % 2 != 0); m = 4'b1011; end
            10: begin r = (a + 1) % 256;   m = 4'b1010; end
            11: begin r = (a + 255) % 256; m = 4'b1010; end
            12: begin r = a; m = 4'b1110; end
            default: begin r = a; m = 4'b0000; end
        endcase
        nn = (r > 127); zz = (r == 0);
        if (op == 12) begin
            nn = (b > 127); vv = ((b / 64) % 2 != 0); zz = ((a & b) == 0);
        end
        e.res = 8'(r);
        if (m[3]) e.n = nn;
        if (m[2]) e.v = vv;
        if (m[1]) e.z = zz;
        if (m[0]) e.c = cc;
        e.mask = m;
        return e;
    endfunction

    // Issue one op, scramble inputs after acceptance, watch a bounded window
    task automatic run_op(input int op, input int a, input int b, input int c, input int d,
                          output logic [15:0] obs, output int lat, output int pulses,
                          output logic busy_seen);
        @(negedge clk);
        alu_op = 4'(op); a_in = 8'(a); b_in = 8'(b);
        c_carry = c[0]; d_decimal = d[0]; compute_step = 1'b1;
        @(posedge clk); #1;
        compute_step = 1'b0;
        busy_seen = busy;
        a_in = 8'($urandom); b_in = 8'($urandom); alu_op = 4'($urandom);
        c_carry = ~c_carry; d_decimal = ~d_decimal;
        lat = 0; pulses = 0; obs = '0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #1;
            if (result_valid) begin
                pulses++;
                if (lat == 0) begin
                    lat = i;
                    obs = {result, flag_n, flag_v, flag_z, flag_c, flag_mask};
                end
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; compute_step = 1'b1;
        alu_op = 4'd3; a_in = 8'h55; b_in = 8'hAA; c_carry = 1'b1; d_decimal = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (result !== 8'h00) begin n_fail++; $display("FAIL reset result: got %02h want 00", result); end
        n_checks++;
        if ({flag_n, flag_v, flag_z, flag_c, flag_mask} !== 8'h00) begin
            n_fail++; $display("FAIL reset flags/mask: got %02h want 00", {flag_n, flag_v, flag_z, flag_c, flag_mask});
        end
        n_checks++;
        if ({busy, result_valid} !== 2'b00) begin
            n_fail++; $display("FAIL reset busy/valid: got %b want 00", {busy, result_valid});
        end
        compute_step = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        model_q = '0;
    endtask

    task automatic test_directed();
        int op_t[11] = '{3, 3, 3, 4, 4, 5, 12, 9, 10, 11, 13};
        int a_t[11]  = '{8'h50, 8'h19, 8'h99, 8'h10, 8'h00, 8'h40, 8'h0F, 8'h01, 8'hFF, 8'h00, 8'h5A};
        int b_t[11]  = '{8'h50, 8'h28, 8'h01, 8'h01, 8'h01, 8'h40, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h33};
        int c_t[11]  = '{0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0};
        int d_t[11]  = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
`ifdef ALU_DECIMAL_EN
        int r_t[11]  = '{8'hA0, 8'h47, 8'h00, 8'h09, 8'hFF, 8'h00, 8'h0F, 8'h80, 8'h00, 8'hFF, 8'h5A};
        int l_t[11]  = '{1, 2, 2, 2, 1, 1, 1, 1, 1, 1, 1};
`else
        int r_t[11]  = '{8'hA0, 8'h41, 8'h9A, 8'h0F, 8'hFF, 8'h00, 8'h0F, 8'h80, 8'h00, 8'hFF, 8'h5A};
        int l_t[11]  = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
`endif
        logic [15:0] obs;
        logic        bsy;
        int          lat, pulses, elat;
        exp_t        e;
        for (int i = 0; i < 11; i++) begin
            e = model(op_t[i], a_t[i], b_t[i], c_t[i], d_t[i], model_q, elat);
            run_op(op_t[i], a_t[i], b_t[i], c_t[i], d_t[i], obs, lat, pulses, bsy);
            n_checks++;
            if (obs[15:8] !== 8'(r_t[i])) begin
                n_fail++; $display("FAIL directed[%0d] result: got %02h want %02h", i, obs[15:8], r_t[i]);
            end
            n_checks++;
            if (lat !== l_t[i]) begin
                n_fail++; $display("FAIL directed[%0d] latency: got %0d want %0d", i, lat, l_t[i]);
            end
            n_checks++;
            if (obs !== e) begin
                n_fail++; $display("FAIL directed[%0d] result/flags/mask: got %04h want %04h", i, obs, e);
            end
            n_checks++;
            if (pulses !== 1 || bsy !== 1'b1) begin
                n_fail++; $display("FAIL directed[%0d] pulses/busy: got %0d/%b want 1/1", i, pulses, bsy);
            end
            model_q = e;
        end
    endtask

    task automatic test_random();
        logic [15:0] obs;
        logic        bsy;
        int          op, a, b, c, d, lat, pulses, elat;
        exp_t        e;
        for (int i = 0; i < 150; i++) begin
            op = int'($urandom_range(0, 15)); a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255)); c = int'($urandom_range(0, 1));
            d = int'($urandom_range(0, 1));
            e = model(op, a, b, c, d, model_q, elat);
            run_op(op, a, b, c, d, obs, lat, pulses, bsy);
            n_checks++;
            if (obs !== e) begin
                n_fail++; $display("FAIL random[%0d] op=%0d a=%02h b=%02h c=%0d d=%0d: got %04h want %04h",
                                   i, op, a, b, c, d, obs, e);
            end
            n_checks++;
            if (lat !== elat) begin
                n_fail++; $display("FAIL random[%0d] latency: got %0d want %0d", i, lat, elat);
            end
            n_checks++;
            if (pulses !== 1) begin
                n_fail++; $display("FAIL random[%0d] pulse count: got %0d want 1", i, pulses);
            end
            model_q = e;
        end
    endtask

    task automatic test_back_to_back();
        int   elat;
        exp_t e1, e2;
        e1 = model(3, 8'h7F, 8'h01, 0, 0, model_q, elat);
        e2 = model(2, 8'hF0, 8'h3C, 0, 0, e1, elat);
        @(negedge clk);
        alu_op = 4'd3; a_in = 8'h7F; b_in = 8'h01; c_carry = 1'b0; d_decimal = 1'b0; compute_step = 1'b1;
        @(posedge clk); #1;
        alu_op = 4'd2; a_in = 8'hF0; b_in = 8'h3C;
        @(posedge clk); #1;
        n_checks++;
        if ({result_valid, busy} !== 2'b10 || {result, flag_n, flag_v, flag_z, flag_c, flag_mask} !== e1) begin
            n_fail++; $display("FAIL b2b first: valid/busy=%b data=%04h want 10/%04h", {result_valid, busy},
                               {result, flag_n, flag_v, flag_z, flag_c, flag_mask}, e1);
        end
        @(posedge clk); #1;
        compute_step = 1'b0;
        n_checks++;
        if ({result_valid, busy} !== 2'b01) begin
            n_fail++; $display("FAIL b2b accept: valid/busy=%b want 01", {result_valid, busy});
        end
        @(posedge clk); #1;
        n_checks++;
        if (result_valid !== 1'b1 || {result, flag_n, flag_v, flag_z, flag_c, flag_mask} !== e2) begin
            n_fail++; $display("FAIL b2b second: valid=%b data=%04h want 1/%04h", result_valid,
                               {result, flag_n, flag_v, flag_z, flag_c, flag_mask}, e2);
        end
        model_q = e2;
    endtask

    task automatic test_hold_step();
        int          elat, lat, pulses;
        logic [15:0] obs;
        exp_t        e;
        e = model(3, 8'h19, 8'h28, 0, 1, model_q, elat);
        @(negedge clk);
        alu_op = 4'd3; a_in = 8'h19; b_in = 8'h28; c_carry = 1'b0; d_decimal = 1'b1; compute_step = 1'b1;
        @(posedge clk); #1;
        lat = 0; pulses = 0; obs = '0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (result_valid) begin
                pulses++;
                if (lat == 0) begin
                    lat = i; obs = {result, flag_n, flag_v, flag_z, flag_c, flag_mask};
                end
                compute_step = 1'b0;
            end
        end
        compute_step = 1'b0;
        n_checks++;
        if (pulses !== 1 || lat !== elat) begin
            n_fail++; $display("FAIL hold_step pulses/latency: got %0d/%0d want 1/%0d", pulses, lat, elat);
        end
        n_checks++;
        if (obs !== e) begin
            n_fail++; $display("FAIL hold_step data: got %04h want %04h", obs, e);
        end
        model_q = e;
    endtask

    task automatic test_reset_mid_op();
        int pulses;
        pulses = 0;
        @(negedge clk);
        alu_op = 4'd3; a_in = 8'h99; b_in = 8'h01; c_carry = 1'b0; d_decimal = 1'b1; compute_step = 1'b1;
        @(posedge clk); #1;
        compute_step = 1'b0;
`ifdef ALU_DECIMAL_EN
        @(posedge clk); #1;
        if (result_valid) pulses++;
`endif
        reset_n = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({busy, result_valid, result, flag_n, flag_v, flag_z, flag_c, flag_mask} !== 18'h0) begin
            n_fail++; $display("FAIL reset_mid_op outputs: got %05h want 00000",
                               {busy, result_valid, result, flag_n, flag_v, flag_z, flag_c, flag_mask});
        end
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (result_valid) pulses++;
        end
        n_checks++;
        if (pulses !== 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_op pulses/busy: got %0d/%b want 0/0", pulses, busy);
        end
        model_q = '0;
    endtask

    initial begin
        clk = 1'b0; reset_n = 1'b0; compute_step = 1'b0;
        alu_op = '0; a_in = '0; b_in = '0; c_carry = 1'b0; d_decimal = 1'b0;
        n_checks = 0; n_fail = 0; model_q = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_hold_step();
        test_random();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
